// File: rtl/cdb_arb_pkg.sv
// rtl/cdb_arb_pkg.sv - shared Tomasulo constants, unit indices and CDB helpers
package cdb_arb_pkg;

    localparam int TAG_W     = 5;
    localparam int VAL_W     = 32;
    localparam int NUM_UNITS = 5;

    localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

    localparam int UNIT_ADD   = 0;
    localparam int UNIT_LOGIC = 1;
    localparam int UNIT_MUL   = 2;
    localparam int UNIT_LOAD  = 3;
    localparam int UNIT_STORE = 4;

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= 3'(NUM_UNITS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [2:0] popcount(input logic [NUM_UNITS-1:0] vec);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cnt = cnt + 3'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cdb_arb_if.sv
// rtl/cdb_arb_if.sv - functional-unit offers and CDB broadcast bundle
interface cdb_arb_if #(
    parameter int TAG_W = cdb_arb_pkg::TAG_W,
    parameter int VAL_W = cdb_arb_pkg::VAL_W
);
    logic             in_request_add,   in_request_logic, in_request_mul;
    logic             in_request_load,  in_request_store;
    logic [TAG_W-1:0] in_tag_add,       in_tag_logic,     in_tag_mul;
    logic [TAG_W-1:0] in_tag_load,      in_tag_store;
    logic [VAL_W-1:0] in_val_add,       in_val_logic,     in_val_mul;
    logic [VAL_W-1:0] in_val_load,      in_val_store;
    logic             out_ready_add,    out_ready_logic,  out_ready_mul;
    logic             out_ready_load,   out_ready_store;
    logic             out_grant_add,    out_grant_logic,  out_grant_mul;
    logic             out_grant_load,   out_grant_store;
    logic             out_broadcast;
    logic [TAG_W-1:0] out_tag;
    logic [VAL_W-1:0] out_val;
    logic [2:0]       out_pending;

    modport slave (
        input  in_request_add, in_request_logic, in_request_mul, in_request_load, in_request_store,
        input  in_tag_add, in_tag_logic, in_tag_mul, in_tag_load, in_tag_store,
        input  in_val_add, in_val_logic, in_val_mul, in_val_load, in_val_store,
        output out_ready_add, out_ready_logic, out_ready_mul, out_ready_load, out_ready_store,
        output out_grant_add, out_grant_logic, out_grant_mul, out_grant_load, out_grant_store,
        output out_broadcast, out_tag, out_val, out_pending
    );

    modport master (
        output in_request_add, in_request_logic, in_request_mul, in_request_load, in_request_store,
        output in_tag_add, in_tag_logic, in_tag_mul, in_tag_load, in_tag_store,
        output in_val_add, in_val_logic, in_val_mul, in_val_load, in_val_store,
        input  out_ready_add, out_ready_logic, out_ready_mul, out_ready_load, out_ready_store,
        input  out_grant_add, out_grant_logic, out_grant_mul, out_grant_load, out_grant_store,
        input  out_broadcast, out_tag, out_val, out_pending
    );

endinterface

// File: rtl/cdb_arb_rr_pick.sv
// rtl/cdb_arb_rr_pick.sv - combinational 5-way round-robin pick starting at ptr
module rr_pick
    import cdb_arb_pkg::*;
(
    input  logic [NUM_UNITS-1:0] valid,
    input  logic [2:0]           ptr,
    output logic [2:0]           winner,
    output logic                 any_valid
);

    logic [2:0] idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = ptr;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!any_valid && valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/cdb_arb.sv
// rtl/cdb_arb.sv - common data bus arbiter with one holding slot per functional unit
module cdb_arb
    import cdb_arb_pkg::*;
#(
    parameter int               TAG_W       = cdb_arb_pkg::TAG_W,
    parameter int               VAL_W       = cdb_arb_pkg::VAL_W,
    parameter logic [TAG_W-1:0] INVALID_TAG = cdb_arb_pkg::INVALID_TAG
) (
    input  logic      clk,
    input  logic      rst,
    cdb_arb_if.slave  bus
);

    logic [NUM_UNITS-1:0] req;
    logic [NUM_UNITS-1:0] accept;
    logic [NUM_UNITS-1:0] slot_valid;
    logic [NUM_UNITS-1:0] valid_next;
    logic [NUM_UNITS-1:0] grant;
    logic [TAG_W-1:0]     in_tag   [NUM_UNITS];
    logic [VAL_W-1:0]     in_val   [NUM_UNITS];
    logic [TAG_W-1:0]     slot_tag [NUM_UNITS];
    logic [VAL_W-1:0]     slot_val [NUM_UNITS];
    logic [2:0]           ptr;
    logic [2:0]           winner;
    logic                 any_valid;
    logic                 broadcast;
    logic [TAG_W-1:0]     bus_tag;
    logic [VAL_W-1:0]     bus_val;
    logic [2:0]           pending;

    always_comb begin
        req = '0;
        req[UNIT_ADD]   = bus.in_request_add;
        req[UNIT_LOGIC] = bus.in_request_logic;
        req[UNIT_MUL]   = bus.in_request_mul;
        req[UNIT_LOAD]  = bus.in_request_load;
        req[UNIT_STORE] = bus.in_request_store;
        in_tag[UNIT_ADD]   = bus.in_tag_add;
        in_tag[UNIT_LOGIC] = bus.in_tag_logic;
        in_tag[UNIT_MUL]   = bus.in_tag_mul;
        in_tag[UNIT_LOAD]  = bus.in_tag_load;
        in_tag[UNIT_STORE] = bus.in_tag_store;
        in_val[UNIT_ADD]   = bus.in_val_add;
        in_val[UNIT_LOGIC] = bus.in_val_logic;
        in_val[UNIT_MUL]   = bus.in_val_mul;
        in_val[UNIT_LOAD]  = bus.in_val_load;
        in_val[UNIT_STORE] = bus.in_val_store;
    end

    rr_pick u_pick (
        .valid     (slot_valid),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Acceptance looks only at the pre-edge slot state, so a slot being granted
    // this edge still reads full and cannot refill until the next edge.
    always_comb begin
        accept = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            accept[u] = req[u] && !slot_valid[u] && (in_tag[u] != INVALID_TAG);
        end
        valid_next = slot_valid;
        if (any_valid) begin
            valid_next[winner] = 1'b0;
        end
        valid_next = valid_next | accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            ptr        <= '0;
            broadcast  <= 1'b0;
            bus_tag    <= INVALID_TAG;
            bus_val    <= '0;
            grant      <= '0;
            pending    <= '0;
        end else begin
            slot_valid <= valid_next;
            pending    <= popcount(valid_next);
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (accept[u]) begin
                    slot_tag[u] <= in_tag[u];
                    slot_val[u] <= in_val[u];
                end
            end
            if (any_valid) begin
                broadcast       <= 1'b1;
                bus_tag         <= slot_tag[winner];
                bus_val         <= slot_val[winner];
                grant           <= '0;
                grant[winner]   <= 1'b1;
                ptr             <= next_idx(winner);
            end else begin
                broadcast <= 1'b0;
                bus_tag   <= INVALID_TAG;
                bus_val   <= '0;
                grant     <= '0;
            end
        end
    end

    assign bus.out_ready_add   = !slot_valid[UNIT_ADD];
    assign bus.out_ready_logic = !slot_valid[UNIT_LOGIC];
    assign bus.out_ready_mul   = !slot_valid[UNIT_MUL];
    assign bus.out_ready_load  = !slot_valid[UNIT_LOAD];
    assign bus.out_ready_store = !slot_valid[UNIT_STORE];
    assign bus.out_grant_add   = grant[UNIT_ADD];
    assign bus.out_grant_logic = grant[UNIT_LOGIC];
    assign bus.out_grant_mul   = grant[UNIT_MUL];
    assign bus.out_grant_load  = grant[UNIT_LOAD];
    assign bus.out_grant_store = grant[UNIT_STORE];
    assign bus.out_broadcast   = broadcast;
    assign bus.out_tag         = bus_tag;
    assign bus.out_val         = bus_val;
    assign bus.out_pending     = pending;

endmodule

// File: tb/tb_cdb_arb.sv
// tb/tb_cdb_arb.sv - directed self-checking bench for the CDB arbiter
module tb_cdb_arb;
    import cdb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cdb_arb_if bus ();

    cdb_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] grants();
        return {bus.out_grant_store, bus.out_grant_load, bus.out_grant_mul,
                bus.out_grant_logic, bus.out_grant_add};
    endfunction

    function automatic logic [4:0] readys();
        return {bus.out_ready_store, bus.out_ready_load, bus.out_ready_mul,
                bus.out_ready_logic, bus.out_ready_add};
    endfunction

    task automatic idle_reqs();
        bus.in_request_add = 0; bus.in_tag_add = '0; bus.in_val_add = '0;
        bus.in_request_logic = 0; bus.in_tag_logic = '0; bus.in_val_logic = '0;
        bus.in_request_mul = 0; bus.in_tag_mul = '0; bus.in_val_mul = '0;
        bus.in_request_load = 0; bus.in_tag_load = '0; bus.in_val_load = '0;
        bus.in_request_store = 0; bus.in_tag_store = '0; bus.in_val_store = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_bus(input string tag, input logic b, input logic [4:0] t,
                             input logic [31:0] v, input logic [4:0] g);
        check({tag, ".bcast"}, 64'(bus.out_broadcast), 64'(b));
        check({tag, ".tag"},   64'(bus.out_tag),       64'(t));
        check({tag, ".val"},   64'(bus.out_val),       64'(v));
        check({tag, ".grant"}, 64'(grants()),          64'(g));
    endtask

    initial begin
        rst = 1'b1;
        idle_reqs();
        step();
        check_bus("reset", 0, 5'h1f, 0, 5'b0);
        check("reset.pending", 64'(bus.out_pending), 64'd0);
        check("reset.ready", 64'(readys()), 64'h1f);
        rst = 1'b0;

        // single mul offer
        bus.in_request_mul = 1; bus.in_tag_mul = 5'd3; bus.in_val_mul = 32'h0000_0010;
        step();
        idle_reqs();
        check("mul.pending1", 64'(bus.out_pending), 64'd1);
        check("mul.ready", 64'(readys()), 64'b11011);
        check("mul.bcast_early", 64'(bus.out_broadcast), 64'd0);
        step();
        check_bus("mul.win", 1, 5'd3, 32'h10, 5'b00100);
        check("mul.pending0", 64'(bus.out_pending), 64'd0);
        step();
        check_bus("mul.idle", 0, 5'h1f, 0, 5'b0);

        // all five at once from ptr=0
        do_reset();
        bus.in_request_add = 1;   bus.in_tag_add = 5'd1;   bus.in_val_add = 32'd101;
        bus.in_request_logic = 1; bus.in_tag_logic = 5'd2; bus.in_val_logic = 32'd102;
        bus.in_request_mul = 1;   bus.in_tag_mul = 5'd3;   bus.in_val_mul = 32'd103;
        bus.in_request_load = 1;  bus.in_tag_load = 5'd4;  bus.in_val_load = 32'd104;
        bus.in_request_store = 1; bus.in_tag_store = 5'd5; bus.in_val_store = 32'd105;
        step();
        idle_reqs();
        check("all5.pending5", 64'(bus.out_pending), 64'd5);
        check("all5.bcast0", 64'(bus.out_broadcast), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_bus($sformatf("all5.win%0d", i), 1, 5'(i + 1), 32'(101 + i), 5'(1 << i));
            check($sformatf("all5.pending%0d", i), 64'(bus.out_pending), 64'(4 - i));
        end
        step();
        check_bus("all5.idle", 0, 5'h1f, 0, 5'b0);

        // add and mul contending continuously: strict alternation
        bus.in_request_add = 1; bus.in_tag_add = 5'd10; bus.in_val_add = 32'hA;
        bus.in_request_mul = 1; bus.in_tag_mul = 5'd12; bus.in_val_mul = 32'hC;
        step();
        check("alt.pending2", 64'(bus.out_pending), 64'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("alt.grant%0d", i), 64'(grants()),
                  (i % 2 == 0) ? 64'b00001 : 64'b00100);
            check($sformatf("alt.bcast%0d", i), 64'(bus.out_broadcast), 64'd1);
        end
        idle_reqs();
        step();
        check_bus("alt.drain", 1, 5'd10, 32'hA, 5'b00001);
        step();
        check_bus("alt.idle", 0, 5'h1f, 0, 5'b0);

        // INVALID_TAG offer is discarded
        do_reset();
        bus.in_request_add = 1; bus.in_tag_add = 5'b11111; bus.in_val_add = 32'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("inv.ready%0d", i), 64'(bus.out_ready_add), 64'd1);
            check($sformatf("inv.pending%0d", i), 64'(bus.out_pending), 64'd0);
            check($sformatf("inv.bcast%0d", i), 64'(bus.out_broadcast), 64'd0);
        end
        idle_reqs();

        // reset mid-operation with a load offer present
        do_reset();
        bus.in_request_add = 1;   bus.in_tag_add = 5'd1;   bus.in_val_add = 32'd1;
        bus.in_request_logic = 1; bus.in_tag_logic = 5'd2; bus.in_val_logic = 32'd2;
        bus.in_request_mul = 1;   bus.in_tag_mul = 5'd3;   bus.in_val_mul = 32'd3;
        step();
        idle_reqs();
        check("rst.pending3", 64'(bus.out_pending), 64'd3);
        rst = 1'b1;
        bus.in_request_load = 1; bus.in_tag_load = 5'd9; bus.in_val_load = 32'd9;
        step();
        rst = 1'b0;
        idle_reqs();
        check_bus("rst.mid", 0, 5'h1f, 0, 5'b0);
        check("rst.mid.pending", 64'(bus.out_pending), 64'd0);
        check("rst.mid.ready", 64'(readys()), 64'h1f);
        for (int i = 0; i < 2; i++) begin
            step();
            check_bus($sformatf("rst.after%0d", i), 0, 5'h1f, 0, 5'b0);
        end

        // full add slot is not overwritten; refill on the edge after its grant
        do_reset();
        bus.in_request_logic = 1; bus.in_tag_logic = 5'd2; bus.in_val_logic = 32'd20;
        step();
        idle_reqs();
        step();
        check_bus("ovr.logic", 1, 5'd2, 32'd20, 5'b00010);
        bus.in_request_add = 1; bus.in_tag_add = 5'd6; bus.in_val_add = 32'd60;
        bus.in_request_mul = 1; bus.in_tag_mul = 5'd3; bus.in_val_mul = 32'd30;
        step();
        bus.in_request_mul = 0;
        bus.in_tag_add = 5'd7; bus.in_val_add = 32'd70;
        check("ovr.pending2", 64'(bus.out_pending), 64'd2);
        step();
        check_bus("ovr.mul", 1, 5'd3, 32'd30, 5'b00100);
        check("ovr.add_held", 64'(bus.out_ready_add), 64'd0);
        step();
        check_bus("ovr.add_old", 1, 5'd6, 32'd60, 5'b00001);
        check("ovr.add_free", 64'(bus.out_ready_add), 64'd1);
        step();
        check("ovr.refill_pending", 64'(bus.out_pending), 64'd1);
        check("ovr.refill_bcast", 64'(bus.out_broadcast), 64'd0);
        idle_reqs();
        step();
        check_bus("ovr.add_new", 1, 5'd7, 32'd70, 5'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arb.md
CDB_ARB -- requirements
Module: cdb_arb

Interface
REQ-001 Parameter TAG_W, default 5, reservation-station tag width.
REQ-002 Parameter VAL_W, default 32, broadcast value width.
REQ-003 Parameter INVALID_TAG, default 5'b11111, "no producer" tag value.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_request_<u>  input  1  unit <u> offers a result; <u> in {add, logic, mul, load, store}.
REQ-007 in_tag_<u>  input  TAG_W  tag of the offered result.
REQ-008 in_val_<u>  input  VAL_W  offered result value.
REQ-009 out_ready_<u>  output  1  unit <u>'s holding slot is empty, so an offer is accepted this cycle.
REQ-010 out_grant_<u>  output  1  one-cycle pulse: unit <u>'s result is on the bus this cycle.
REQ-011 out_broadcast  output  1  CDB valid.
REQ-012 out_tag  output  TAG_W  CDB tag.
REQ-013 out_val  output  VAL_W  CDB value.
REQ-014 out_pending  output  3  count of occupied holding slots, 0..5.

Function
REQ-015 Each unit SHALL own one holding slot {valid, tag, val}; the bus SHALL carry at most one result per cycle.
REQ-016 out_ready_<u> SHALL equal !slot_valid[<u>] (combinational from state only).
REQ-017 An offer is accepted at an edge when in_request_<u> && out_ready_<u> && in_tag_<u> != INVALID_TAG; the slot SHALL load tag and val at that edge.
REQ-018 An offer carrying INVALID_TAG SHALL be discarded, with no slot change.
REQ-019 An offer while the slot is full SHALL be ignored; the unit holds it until ready (no loss, no overwrite).
REQ-020 Each cycle, arbitration SHALL pick the first valid slot in round-robin order, starting at index ptr; indices: add=0, logic=1, mul=2, load=3, store=4.
REQ-021 At the edge after a win, the arbiter SHALL register out_broadcast=1, out_tag/out_val from the slot, and out_grant_<winner>=1, clear the slot, and set ptr <= (winner+1) mod 5.
REQ-022 With no valid slot: out_broadcast=0, out_tag=INVALID_TAG, out_val=0, all grants 0, ptr unchanged.
REQ-023 A slot cleared by a grant SHALL NOT accept a new offer at the same edge; earliest refill is the following edge.
REQ-024 Latency: offer accepted at edge k with no contention -> broadcast visible in the cycle after edge k+1 (2 edges), held exactly 1 cycle.
REQ-025 Worst-case wait after acceptance SHALL be 5 broadcast cycles (starvation-free).
REQ-026 out_pending SHALL be registered: popcount of slot_valid after each edge.

Reset
REQ-027 On rst=1 at an edge: all slot_valid=0, ptr=0, out_broadcast=0, out_tag=INVALID_TAG, out_val=0, grants=0, out_pending=0.
REQ-028 Reset mid-operation SHALL drop all held results; offers present during the reset cycle SHALL NOT be accepted.

Structure
REQ-029 INVALID_TAG, TAG_W, VAL_W and the unit index constants SHALL live in the shared Tomasulo package used by the CDB, RS_MUX and reservation stations.
REQ-030 Sub-module rr_pick SHALL implement the 5-way round-robin priority pick (inputs: valid vector and ptr; outputs: winner index and any_valid), purely combinational.
REQ-031 cdb_arb SHALL drop in for the CDB requester wiring, with unused units tied to request=0.

Verification
REQ-032 Single mul offer tag=3, val=0x0000_0010 at edge 1 -> cycle after edge 2: out_broadcast=1, out_tag=3, out_val=0x10, out_grant_mul=1, then the bus is idle.
REQ-033 All five offer tags 1..5 in the same cycle with ptr=0 -> five consecutive broadcasts, tags 1,2,3,4,5, each grant pulsed once, out_pending 5,4,3,2,1,0.
REQ-034 add re-offers on every ready cycle while mul offers continuously -> grants alternate add/mul, neither waits more than 1 broadcast cycle.
REQ-035 Offer with tag=5'b11111 -> never accepted, out_ready stays 1, no broadcast.
REQ-036 Three slots full, then rst=1 for one cycle while load offers -> after the edge all outputs at reset values, out_pending=0, load's offer not broadcast.
REQ-037 add slot full and add keeps offering tag=7 -> no overwrite; tag=7 is accepted on the edge after the grant of the held result.
